leading_one_normalizer: RTL

//   Consumer stage for the leading-one position encoder. Accepts an operand and its

---
 rtl/leading_one_normalizer.sv | 135 +++++++++++++
 1 files changed

// File: rtl/leading_one_normalizer.sv
// ---------------------------------------------------------------------------
// leading_one_normalizer
//   Consumer stage for the leading-one position encoder. Takes an operand plus
//   the index of its most-significant set bit, and left-shifts the operand so
//   that its MSB becomes 1. Reports the applied shift, a zero-operand flag and
//   a saturating count of zero operands delivered downstream.
//   Two-stage valid/ready pipeline (stage 1: decode, stage 2: shift/output).
//
// Ports
//   clk        in   1           rising-edge clock
//   rst        in   1           synchronous reset, active-high
//   in_valid   in   1           in_data/in_pos valid
//   in_ready   out  1           stage can accept this cycle
//   in_data    in   WIDTH       operand
//   in_pos     in   LOG2_WIDTH  index of highest set bit (0 when in_data==0)
//   out_valid  out  1           result valid
//   out_ready  in   1           downstream accepts
//   out_data   out  WIDTH       normalised operand
//   out_shift  out  LOG2_WIDTH  left-shift applied
//   out_zero   out  1           operand was all zeros
//   clr_cnt    in   1           synchronous clear of zero_cnt
//   zero_cnt   out  CNT_WIDTH   zero operands delivered, saturating
// ---------------------------------------------------------------------------
module leading_one_normalizer #(
  parameter int WIDTH      = 4,
  parameter int LOG2_WIDTH = $clog2(WIDTH),
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [WIDTH-1:0]      in_data,
  input  logic [LOG2_WIDTH-1:0] in_pos,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [WIDTH-1:0]      out_data,
  output logic [LOG2_WIDTH-1:0] out_shift,
  output logic                  out_zero,
  input  logic                  clr_cnt,
  output logic [CNT_WIDTH-1:0]  zero_cnt
);

  // Highest legal bit index; shift = MAX_POS - in_pos stays in range because
  // a consistent in_pos never exceeds it.
  localparam logic [LOG2_WIDTH-1:0] MAX_POS = LOG2_WIDTH'(WIDTH - 1);
  localparam logic [CNT_WIDTH-1:0]  CNT_MAX = {CNT_WIDTH{1'b1}};
  localparam logic [CNT_WIDTH-1:0]  CNT_ONE = CNT_WIDTH'(1);

  // Stage-1 registers
  logic                  s1_valid;
  logic [WIDTH-1:0]      s1_data;
  logic [LOG2_WIDTH-1:0] s1_shift;
  logic                  s1_zero;

  // Combinational decode / handshake
  logic                  in_zero;
  logic [LOG2_WIDTH-1:0] in_shift;
  logic                  s1_adv;
  logic                  s2_adv;
  logic                  out_xfer;

  // Operand decode and pipeline advance conditions.
  always_comb begin
    in_zero  = ~|in_data;
    in_shift = {LOG2_WIDTH{1'b0}};
    if (in_zero) begin
      // A zero operand has no leading one: never shift it, whatever in_pos says.
      in_shift = {LOG2_WIDTH{1'b0}};
    end else begin
      in_shift = MAX_POS - in_pos;
    end
    // Stage 2 can take a new item when empty or being drained this cycle;
    // stage 1 can when empty or when it is moving into stage 2.
    s2_adv   = ~out_valid | out_ready;
    s1_adv   = ~s1_valid | s2_adv;
    out_xfer = out_valid & out_ready;
  end

  assign in_ready = s1_adv;

  // Stage 1: capture operand, zero flag and computed shift.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_data  <= {WIDTH{1'b0}};
      s1_shift <= {LOG2_WIDTH{1'b0}};
      s1_zero  <= 1'b0;
    end else if (s1_adv) begin
      s1_valid <= in_valid;
      s1_data  <= in_data;
      s1_shift <= in_shift;
      s1_zero  <= in_zero;
    end else begin
      s1_valid <= s1_valid;
      s1_data  <= s1_data;
      s1_shift <= s1_shift;
      s1_zero  <= s1_zero;
    end
  end

  // Stage 2: apply the shift; output fields hold while stalled.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= {WIDTH{1'b0}};
      out_shift <= {LOG2_WIDTH{1'b0}};
      out_zero  <= 1'b0;
    end else if (s2_adv) begin
      out_valid <= s1_valid;
      out_data  <= s1_data << s1_shift;
      out_shift <= s1_shift;
      out_zero  <= s1_zero;
    end else begin
      out_valid <= out_valid;
      out_data  <= out_data;
      out_shift <= out_shift;
      out_zero  <= out_zero;
    end
  end

  // Saturating zero-operand counter; clear wins over a same-cycle increment.
  always_ff @(posedge clk) begin
    if (rst) begin
      zero_cnt <= {CNT_WIDTH{1'b0}};
    end else if (clr_cnt) begin
      zero_cnt <= {CNT_WIDTH{1'b0}};
    end else if (out_xfer && out_zero && (zero_cnt != CNT_MAX)) begin
      zero_cnt <= zero_cnt + CNT_ONE;
    end else begin
      zero_cnt <= zero_cnt;
    end
  end

endmodule
